// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with a held, handshaked output word.
// Optional per-frame even-parity check is enabled by defining SIPO_PARITY_EN.
module sipo_deser #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           si,
  input  logic                           si_valid,
  input  logic                           clr,
  output logic [WIDTH-1:0]               po,
  output logic                           po_valid,
  input  logic                           po_ready,
  output logic                           busy,
  output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
  output logic                           overrun,
  output logic                           parity_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int unsigned LAST_CNT = WIDTH;
`else
  localparam int unsigned LAST_CNT = WIDTH - 1;
`endif

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] word_c;
  logic             complete_c;
  logic             accept_c;
`ifdef SIPO_PARITY_EN
  logic             perr_q, perr_d;
`endif

  assign shifted_c  = MSB_FIRST ? {sr_q[WIDTH-2:0], si} : {si, sr_q[WIDTH-1:1]};
  assign complete_c = si_valid && (cnt_q == CW'(LAST_CNT));
  assign accept_c   = !po_valid_q || po_ready;
`ifdef SIPO_PARITY_EN
  // Parity bit arrives after the data bits, so the word is already assembled.
  assign word_c     = sr_q;
`else
  assign word_c     = shifted_c;
`endif

  // Frame assembly, word hand-off and flag update.
  always_comb begin
    sr_d       = sr_q;
    po_d       = po_q;
    cnt_d      = cnt_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;
`ifdef SIPO_PARITY_EN
    perr_d     = perr_q;
`endif
    if (po_valid_q && po_ready) begin
      po_valid_d = 1'b0;
    end
    if (clr) begin
      sr_d       = '0;
      cnt_d      = '0;
      po_valid_d = 1'b0;
      overrun_d  = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_d     = 1'b0;
`endif
    end else if (si_valid) begin
      if (complete_c) begin
        sr_d  = '0;
        cnt_d = '0;
        if (accept_c) begin
          po_d       = word_c;
          po_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
          perr_d     = (^sr_q) ^ si;
`endif
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        sr_d  = shifted_c;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q       <= '0;
      po_q       <= '0;
      cnt_q      <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      sr_q       <= sr_d;
      po_q       <= po_d;
      cnt_q      <= cnt_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
`ifdef SIPO_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign bit_cnt  = cnt_q;
  assign overrun  = overrun_q;
  assign busy     = (cnt_q != '0);
`ifdef SIPO_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
